// File: rtl/qspi_xip_arbiter_pkg.sv
// Shared types and constants for the QSPI XIP read-port arbiter.
package qspi_xip_arbiter_pkg;

    localparam int unsigned QspiDw = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } xip_arb_state_e;

endpackage

// File: rtl/qspi_xip_arbiter_if.sv
// Requester-side and qspi_xip-side signals of the XIP read-port arbiter.
interface qspi_xip_arbiter_if #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned AddrW  = 24
);
    import qspi_xip_arbiter_pkg::*;

    logic [NumReq-1:0]       req_i;
    logic [NumReq*AddrW-1:0] addr_i;
    logic [NumReq-1:0]       gnt_o;
    logic [NumReq-1:0]       rvalid_o;
    logic                    rerr_o;
    logic [QspiDw-1:0]       rdata_o;
    logic                    xip_req_o;
    logic [AddrW-1:0]        xip_addr_o;
    logic [QspiDw-1:0]       xip_rdata_i;
    logic                    xip_rvalid_i;
    logic                    busy_o;

    modport slave (
        input  req_i, addr_i, xip_rdata_i, xip_rvalid_i,
        output gnt_o, rvalid_o, rerr_o, rdata_o, xip_req_o, xip_addr_o, busy_o
    );

    modport master (
        output req_i, addr_i, xip_rdata_i, xip_rvalid_i,
        input  gnt_o, rvalid_o, rerr_o, rdata_o, xip_req_o, xip_addr_o, busy_o
    );

endinterface

// File: rtl/qspi_xip_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module qspi_xip_arbiter_rr_arbiter #(
    parameter  int unsigned N    = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx
);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum = {1'b0, ptr} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(N)) begin
                sum = sum - (IdxW+1)'(N);
            end
            cand = sum[IdxW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/qspi_xip_arbiter.sv
// Round-robin share of the single qspi_xip read port with one outstanding read
// and a watchdog that turns hung reads into error responses.
module qspi_xip_arbiter
    import qspi_xip_arbiter_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned AddrW         = 24,
    parameter int unsigned TimeoutCycles = 1024
) (
    input logic                clk_i,
    input logic                rst_ni,
    qspi_xip_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned TmrW = $clog2(TimeoutCycles + 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

    xip_arb_state_e    state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [QspiDw-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic              drain_q, drain_d;
    logic [NumReq-1:0] rvalid_q, rvalid_d;
    logic              xip_req_q, xip_req_d;
    logic              busy_q, busy_d;

    logic [NumReq-1:0] arb_gnt;
    logic [IdxW-1:0]   arb_idx;
    logic [NumReq-1:0] gnt_c;
    logic [AddrW-1:0]  req_addr [NumReq];
    logic [AddrW-1:0]  win_addr;

    qspi_xip_arbiter_rr_arbiter #(
        .N (NumReq)
    ) u_rr (
        .req (bus.req_i),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    for (genvar g = 0; g < NumReq; g++) begin : g_addr
        assign req_addr[g] = bus.addr_i[g*AddrW +: AddrW];
    end

    assign win_addr = req_addr[arb_idx];

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        timer_d = timer_q;
        drain_d = drain_q;
        gnt_c   = '0;

        unique case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    gnt_c   = arb_gnt;
                    owner_d = arb_idx;
                    addr_d  = win_addr & ~AddrW'(3);
                    ptr_d   = (arb_idx == IdxLast) ? '0 : arb_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                // A beat landing on the expiry cycle still counts as data.
                if (bus.xip_rvalid_i) begin
                    rdata_d = bus.xip_rdata_i;
                    rerr_d  = 1'b0;
                    drain_d = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TmrLast) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    drain_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                timer_d = '0;
                drain_d = 1'b0;
                state_d = drain_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (bus.xip_rvalid_i || (timer_q == TmrLast)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rvalid_d = '0;
        if (state_d == RESP) rvalid_d = NumReq'(1) << owner_d;
        xip_req_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
            timer_q   <= '0;
            drain_q   <= 1'b0;
            rvalid_q  <= '0;
            xip_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            timer_q   <= timer_d;
            drain_q   <= drain_d;
            rvalid_q  <= rvalid_d;
            xip_req_q <= xip_req_d;
            busy_q    <= busy_d;
        end
    end

    // Grant is combinational; keep it quiet while reset is asserted.
    assign bus.gnt_o      = gnt_c & {NumReq{rst_ni}};
    assign bus.rvalid_o   = rvalid_q;
    assign bus.rerr_o     = rerr_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.xip_req_o  = xip_req_q;
    assign bus.xip_addr_o = addr_q;
    assign bus.busy_o     = busy_q;

endmodule
